// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and writeback.
// Drives the dmem req/gnt/rvalid bus for loads and stores, aligns and
// extends load data, and presents a registered writeback bundle.
// Optional feature macro: MEM_STAGE_MISALIGN_CHECK_EN (suppress misaligned
// half/word accesses and pulse misalign_o instead of touching the bus).
module mem_stage #(
  parameter bit RESP_BUF_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_width_i,
  input  logic        mem_sign_i,
  input  logic        rf_wr_en_i,
  input  logic [1:0]  rf_wr_src_i,
  input  logic [31:0] next_pc_i,
  input  logic [4:0]  rd_i,
  input  logic        stall_i,
  input  logic        squash_i,
  output logic        busy_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_alu_out_o,
  output logic [31:0] wb_mem_dout_o,
  output logic [31:0] wb_next_pc_o,
  output logic        wb_rf_wr_en_o,
  output logic [1:0]  wb_rf_wr_src_o,
  output logic        wb_mem_read_o,
  output logic [4:0]  wb_rd_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;
  state_t state_q, state_d;

  // captured request / writeback fields for the outstanding access
  logic [31:0] q_alu, q_wdata, q_next_pc, buf_q;
  logic [3:0]  q_be;
  logic [1:0]  q_width, q_rf_wr_src;
  logic [4:0]  q_rd;
  logic        q_we, q_sign, q_rf_wr_en, q_mem_read, drop_q;

  logic mem_op, mis, start, mis_acc, rsp, hold_ok, ld_rsp, ld_buf, wb_from_mem, drop_eff;
  logic [31:0] ld_data;

  function automatic logic [3:0] st_be(input logic we, input logic [1:0] w, input logic [1:0] off);
    logic [3:0] r;
    r = 4'hF;
    if (we) begin
      case (w)
        2'd0:    r = 4'b0001 << off;
        2'd1:    r = off[1] ? 4'b1100 : 4'b0011;
        default: r = 4'hF;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] st_wd(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    case (w)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_align(input logic [31:0] d, input logic [1:0] w,
                                           input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (w)
      2'd0:    r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'd1:    r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign mis = (mem_width_i == 2'd1) ? alu_out_i[0]
             : (mem_width_i[1] ? (|alu_out_i[1:0]) : 1'b0);
`else
  assign mis = 1'b0;
`endif

  assign mem_op  = !rst_i && (state_q == IDLE) && valid_i && (mem_read_i || mem_write_i)
                   && !squash_i && !stall_i;
  assign start   = mem_op && !mis;
  assign mis_acc = mem_op && mis;

  // a response completes the access in RESP, or in REQ when gnt and rvalid coincide
  assign rsp         = dmem_rvalid_i && ((state_q == RESP) || ((state_q == REQ) && dmem_gnt_i));
  assign hold_ok     = RESP_BUF_EN ? stall_i : 1'b0;
  assign ld_rsp      = rsp && !hold_ok;
  assign ld_buf      = (state_q == HOLD) && !stall_i;
  assign wb_from_mem = ld_rsp || ld_buf;
  assign drop_eff    = drop_q || squash_i;
  assign ld_data     = q_we ? 32'h0 : ld_align(dmem_rdata_i, q_width, q_sign, q_alu[1:0]);

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = dmem_gnt_i ? RESP : REQ;
      REQ:  if (rsp) state_d = hold_ok ? HOLD : IDLE;
            else if (dmem_gnt_i) state_d = RESP;
      RESP: if (rsp) state_d = hold_ok ? HOLD : IDLE;
      HOLD: if (!stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // bus outputs: live from execute inputs on the issue cycle, captured copy while in REQ
  always_comb begin
    busy_o       = !rst_i && (((state_q != IDLE) && !wb_from_mem) || start);
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_be_o    = 4'h0;
    dmem_wdata_o = 32'h0;
    if (start) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = mem_write_i;
      dmem_addr_o  = {alu_out_i[31:2], 2'b00};
      dmem_be_o    = st_be(mem_write_i, mem_width_i, alu_out_i[1:0]);
      dmem_wdata_o = mem_write_i ? st_wd(mem_width_i, store_data_i) : 32'h0;
    end else if (!rst_i && (state_q == REQ)) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = q_we;
      dmem_addr_o  = {q_alu[31:2], 2'b00};
      dmem_be_o    = q_be;
      dmem_wdata_o = q_wdata;
    end
  end

  // capture request and writeback fields when an access is issued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_alu <= '0; q_wdata <= '0; q_next_pc <= '0; q_be <= '0; q_width <= '0;
      q_rf_wr_src <= '0; q_rd <= '0; q_we <= 1'b0; q_sign <= 1'b0;
      q_rf_wr_en <= 1'b0; q_mem_read <= 1'b0;
    end else if (start) begin
      q_alu       <= alu_out_i;
      q_wdata     <= mem_write_i ? st_wd(mem_width_i, store_data_i) : 32'h0;
      q_be        <= st_be(mem_write_i, mem_width_i, alu_out_i[1:0]);
      q_we        <= mem_write_i;
      q_width     <= mem_width_i;
      q_sign      <= mem_sign_i;
      q_next_pc   <= next_pc_i;
      q_rf_wr_en  <= rf_wr_en_i;
      q_rf_wr_src <= rf_wr_src_i;
      q_mem_read  <= mem_read_i;
      q_rd        <= rd_i;
    end
  end

  // squash of an in-flight access is remembered until its response retires
  always_ff @(posedge clk_i) begin
    if (rst_i)                                drop_q <= 1'b0;
    else if (wb_from_mem)                     drop_q <= 1'b0;
    else if ((state_q != IDLE) && squash_i)   drop_q <= 1'b1;
  end

  // hold buffer for a response that lands while the stage is stalled
  always_ff @(posedge clk_i) begin
    if (rst_i)                   buf_q <= '0;
    else if (rsp && hold_ok)     buf_q <= ld_data;
  end

  // writeback bundle register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0; wb_alu_out_o <= '0; wb_mem_dout_o <= '0; wb_next_pc_o <= '0;
      wb_rf_wr_en_o <= 1'b0; wb_rf_wr_src_o <= '0; wb_mem_read_o <= 1'b0; wb_rd_o <= '0;
    end else if (wb_from_mem) begin
      wb_valid_o     <= !drop_eff;
      wb_alu_out_o   <= q_alu;
      wb_mem_dout_o  <= ld_rsp ? ld_data : buf_q;
      wb_next_pc_o   <= q_next_pc;
      wb_rf_wr_en_o  <= q_rf_wr_en && !drop_eff;
      wb_rf_wr_src_o <= q_rf_wr_src;
      wb_mem_read_o  <= q_mem_read;
      wb_rd_o        <= q_rd;
    end else if ((state_q == IDLE) && !stall_i) begin
      if (start) begin
        wb_valid_o <= 1'b0;
      end else begin
        // non-memory, squashed, or suppressed misaligned access
        wb_valid_o     <= valid_i && !squash_i;
        wb_alu_out_o   <= alu_out_i;
        wb_mem_dout_o  <= 32'h0;
        wb_next_pc_o   <= next_pc_i;
        wb_rf_wr_en_o  <= rf_wr_en_i && !mis_acc;
        wb_rf_wr_src_o <= rf_wr_src_i;
        wb_mem_read_o  <= mem_read_i;
        wb_rd_o        <= rd_i;
      end
    end
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  // one-cycle pulse when a misaligned access is suppressed
  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_o <= 1'b0;
    else       misalign_o <= mis_acc;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed accesses push expected writeback
// bundles; a negedge monitor pops and compares whenever wb_valid_o is high.
module tb_mem_stage;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, mem_read_i, mem_write_i, mem_sign_i, rf_wr_en_i;
  logic        stall_i, squash_i, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] alu_out_i, store_data_i, next_pc_i, dmem_rdata_i;
  logic [1:0]  mem_width_i, rf_wr_src_i;
  logic [4:0]  rd_i;
  logic        busy_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_rf_wr_en_o, wb_mem_read_o, misalign_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_alu_out_o, wb_mem_dout_o, wb_next_pc_o;
  logic [3:0]  dmem_be_o;
  logic [1:0]  wb_rf_wr_src_o;
  logic [4:0]  wb_rd_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] alu, dout, npc;
    logic        rfwe;
    logic [1:0]  src;
    logic        mr;
    logic [4:0]  rd;
  } wb_t;
  wb_t exp_q[$];
  wb_t mon_e;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_out_i(alu_out_i),
    .store_data_i(store_data_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_width_i(mem_width_i), .mem_sign_i(mem_sign_i), .rf_wr_en_i(rf_wr_en_i),
    .rf_wr_src_i(rf_wr_src_i), .next_pc_i(next_pc_i), .rd_i(rd_i), .stall_i(stall_i),
    .squash_i(squash_i), .busy_o(busy_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_alu_out_o(wb_alu_out_o), .wb_mem_dout_o(wb_mem_dout_o),
    .wb_next_pc_o(wb_next_pc_o), .wb_rf_wr_en_o(wb_rf_wr_en_o), .wb_rf_wr_src_o(wb_rf_wr_src_o),
    .wb_mem_read_o(wb_mem_read_o), .wb_rd_o(wb_rd_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] dout, input logic [31:0] npc,
                      input logic rfwe, input logic [1:0] src, input logic mr, input logic [4:0] rd);
    wb_t e;
    e.alu = alu; e.dout = dout; e.npc = npc; e.rfwe = rfwe; e.src = src; e.mr = mr; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // monitor: every presented writeback result must match the oldest expectation
  always @(negedge clk_i) begin
    if (!rst_i && wb_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wb_unexpected: got alu=%h with no expected entry", wb_alu_out_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_alu_out", wb_alu_out_o, mon_e.alu);
        chk("wb_mem_dout", wb_mem_dout_o, mon_e.dout);
        chk("wb_next_pc", wb_next_pc_o, mon_e.npc);
        chk("wb_ctrl", {23'b0, wb_rf_wr_en_o, wb_rf_wr_src_o, wb_mem_read_o, wb_rd_o},
            {23'b0, mon_e.rfwe, mon_e.src, mon_e.mr, mon_e.rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_instr();
    valid_i = 0; alu_out_i = 0; store_data_i = 0; mem_read_i = 0; mem_write_i = 0;
    mem_width_i = 0; mem_sign_i = 0; rf_wr_en_i = 0; rf_wr_src_i = 0; next_pc_i = 0; rd_i = 0;
  endtask

  task automatic set_instr(input logic [31:0] alu, input logic [31:0] sd, input logic mr,
                           input logic mw, input logic [1:0] w, input logic sgn, input logic rfwe,
                           input logic [1:0] src, input logic [31:0] npc, input logic [4:0] rd);
    valid_i = 1; alu_out_i = alu; store_data_i = sd; mem_read_i = mr; mem_write_i = mw;
    mem_width_i = w; mem_sign_i = sgn; rf_wr_en_i = rfwe; rf_wr_src_i = src;
    next_pc_i = npc; rd_i = rd;
  endtask

  task automatic idle(input int n);
    clear_instr();
    repeat (n) tick();
  endtask

  // Bus responder for one access already presented on the inputs: gnt at cycle gd,
  // rvalid rd_ cycles after gnt, optional stall from the response for stall_len
  // cycles, optional squash pulse at cycle sq_k. Checks the issued bus fields.
  task automatic run_mem(input int gd, input int rd_, input logic [31:0] rdata,
                         input int stall_len, input int sq_k, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] addr,
                         output int busy_n, output int req_after);
    int last;
    last = gd + rd_ + stall_len;
    busy_n = 0; req_after = 0;
    for (int k = 0; k <= last; k++) begin
      dmem_gnt_i    = (k == gd);
      dmem_rvalid_i = (k == gd + rd_);
      dmem_rdata_i  = (k == gd + rd_) ? rdata : 32'h0;
      stall_i       = (stall_len > 0) && (k >= gd + rd_) && (k < last);
      squash_i      = (k == sq_k);
      @(negedge clk_i);
      if (busy_o) busy_n++;
      if (k > gd && dmem_req_o) req_after++;
      if (k == 0 || k == gd) begin
        chk("dmem_req", {31'b0, dmem_req_o}, 32'h1);
        chk("dmem_we", {31'b0, dmem_we_o}, {31'b0, we});
        chk("dmem_be", {28'b0, dmem_be_o}, {28'b0, be});
        chk("dmem_wdata", dmem_wdata_o, wdata);
        chk("dmem_addr", dmem_addr_o, addr);
      end
      tick();
    end
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0; stall_i = 0; squash_i = 0;
    clear_instr();
  endtask

  int bn, ra;

  initial begin
    clear_instr();
    rst_i = 1; stall_i = 0; squash_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    repeat (2) tick();
    @(negedge clk_i);
    chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_req", {31'b0, dmem_req_o}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'h0);
    chk("rst_wb_alu", wb_alu_out_o, 32'h0);
    tick();
    rst_i = 0;

    // add: latency 1
    set_instr(32'h55, 0, 0, 0, 2'd2, 0, 1, 2'd0, 32'h104, 5'd3);
    push(32'h55, 0, 32'h104, 1, 2'd0, 0, 5'd3);
    @(negedge clk_i);
    chk("add_busy", {31'b0, busy_o}, 32'h0);
    chk("add_req", {31'b0, dmem_req_o}, 32'h0);
    tick(); clear_instr();
    @(negedge clk_i);
    chk("add_lat1_valid", {31'b0, wb_valid_o}, 32'h1);
    idle(1);

    // squashed add and squashed lw in IDLE
    set_instr(32'h66, 0, 0, 0, 2'd2, 0, 1, 2'd0, 32'h108, 5'd4);
    squash_i = 1;
    tick(); squash_i = 0; clear_instr();
    @(negedge clk_i);
    chk("sq_add_valid", {31'b0, wb_valid_o}, 32'h0);
    tick();
    set_instr(32'h100, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h10C, 5'd4);
    squash_i = 1;
    @(negedge clk_i);
    chk("sq_lw_req", {31'b0, dmem_req_o}, 32'h0);
    chk("sq_lw_busy", {31'b0, busy_o}, 32'h0);
    tick(); squash_i = 0; idle(1);

    // lw 0x100: gnt after 2 cycles, rvalid 3 later -> busy 5 cycles
    set_instr(32'h100, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h104, 5'd5);
    push(32'h100, 32'hDEADBEEF, 32'h104, 1, 2'd1, 1, 5'd5);
    run_mem(2, 3, 32'hDEADBEEF, 0, -1, 0, 4'hF, 32'h0, 32'h100, bn, ra);
    chk("lw_busy_cycles", bn, 5);
    chk("lw_req_after_gnt", ra, 0);
    idle(2);

    // lb signed / lbu at 0x103
    set_instr(32'h103, 0, 1, 0, 2'd0, 1, 1, 2'd1, 32'h108, 5'd6);
    push(32'h103, 32'hFFFFFF80, 32'h108, 1, 2'd1, 1, 5'd6);
    run_mem(1, 1, 32'h80000000, 0, -1, 0, 4'hF, 32'h0, 32'h100, bn, ra);
    idle(2);
    set_instr(32'h103, 0, 1, 0, 2'd0, 0, 1, 2'd1, 32'h10C, 5'd7);
    push(32'h103, 32'h00000080, 32'h10C, 1, 2'd1, 1, 5'd7);
    run_mem(1, 1, 32'h80000000, 0, -1, 0, 4'hF, 32'h0, 32'h100, bn, ra);
    idle(2);

    // sh 0x102 with gnt on the issue cycle
    set_instr(32'h102, 32'h1234ABCD, 0, 1, 2'd1, 0, 0, 2'd0, 32'h110, 5'd0);
    push(32'h102, 32'h0, 32'h110, 0, 2'd0, 0, 5'd0);
    run_mem(0, 2, 32'h0, 0, -1, 1, 4'b1100, 32'hABCDABCD, 32'h100, bn, ra);
    chk("sh_busy_cycles", bn, 2);
    idle(2);

    // lw squashed while in RESP, then an add completes in one cycle
    set_instr(32'h400, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h114, 5'd9);
    run_mem(1, 3, 32'h11111111, 0, 2, 0, 4'hF, 32'h0, 32'h400, bn, ra);
    @(negedge clk_i);
    chk("sq_resp_valid", {31'b0, wb_valid_o}, 32'h0);
    chk("sq_resp_rfwe", {31'b0, wb_rf_wr_en_o}, 32'h0);
    chk("sq_resp_busy", {31'b0, busy_o}, 32'h0);
    tick();
    set_instr(32'h77, 0, 0, 0, 2'd2, 0, 1, 2'd0, 32'h118, 5'd10);
    push(32'h77, 0, 32'h118, 1, 2'd0, 0, 5'd10);
    @(negedge clk_i);
    chk("post_sq_busy", {31'b0, busy_o}, 32'h0);
    tick(); clear_instr();
    @(negedge clk_i);
    chk("post_sq_add_valid", {31'b0, wb_valid_o}, 32'h1);
    idle(1);

    // stall on rvalid -> HOLD, released two cycles later
    set_instr(32'h200, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h11C, 5'd8);
    push(32'h200, 32'h13579BDF, 32'h11C, 1, 2'd1, 1, 5'd8);
    run_mem(1, 1, 32'h13579BDF, 2, -1, 0, 4'hF, 32'h0, 32'h200, bn, ra);
    chk("hold_busy_cycles", bn, 4);
    chk("hold_no_second_req", ra, 0);
    idle(2);

    // gnt and rvalid together while in REQ
    set_instr(32'h300, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h120, 5'd11);
    push(32'h300, 32'h0BADF00D, 32'h120, 1, 2'd1, 1, 5'd11);
    run_mem(2, 0, 32'h0BADF00D, 0, -1, 0, 4'hF, 32'h0, 32'h300, bn, ra);
    chk("req_gnt_rvalid_busy", bn, 2);
    idle(2);

    // lh signed 0x102 (upper half)
    set_instr(32'h102, 0, 1, 0, 2'd1, 1, 1, 2'd1, 32'h124, 5'd12);
    push(32'h102, 32'hFFFF8001, 32'h124, 1, 2'd1, 1, 5'd12);
    run_mem(1, 1, 32'h80010000, 0, -1, 0, 4'hF, 32'h0, 32'h100, bn, ra);
    idle(2);

    // sb 0x101
    set_instr(32'h101, 32'h000000A5, 0, 1, 2'd0, 0, 0, 2'd0, 32'h128, 5'd0);
    push(32'h101, 32'h0, 32'h128, 0, 2'd0, 0, 5'd0);
    run_mem(1, 1, 32'h0, 0, -1, 1, 4'b0010, 32'hA5A5A5A5, 32'h100, bn, ra);
    idle(2);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    // misaligned lw is suppressed
    set_instr(32'h1001, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h12C, 5'd13);
    push(32'h1001, 32'h0, 32'h12C, 0, 2'd1, 1, 5'd13);
    @(negedge clk_i);
    chk("mis_req", {31'b0, dmem_req_o}, 32'h0);
    chk("mis_busy", {31'b0, busy_o}, 32'h0);
    tick(); clear_instr();
    @(negedge clk_i);
    chk("mis_pulse", {31'b0, misalign_o}, 32'h1);
    chk("mis_req_next", {31'b0, dmem_req_o}, 32'h0);
    tick();
    @(negedge clk_i);
    chk("mis_pulse_end", {31'b0, misalign_o}, 32'h0);
    idle(1);
`else
    // low address bits ignored: lw 0x1001 proceeds on word 0x1000
    set_instr(32'h1001, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h12C, 5'd13);
    push(32'h1001, 32'hCAFEF00D, 32'h12C, 1, 2'd1, 1, 5'd13);
    run_mem(1, 1, 32'hCAFEF00D, 0, -1, 0, 4'hF, 32'h0, 32'h1000, bn, ra);
    @(negedge clk_i);
    chk("no_misalign", {31'b0, misalign_o}, 32'h0);
    idle(2);
`endif

    // reset mid-transaction, then a late rvalid in IDLE is ignored
    set_instr(32'h500, 0, 1, 0, 2'd2, 0, 1, 2'd1, 32'h130, 5'd14);
    tick(); tick();
    rst_i = 1; clear_instr();
    tick();
    rst_i = 0;
    @(negedge clk_i);
    chk("mid_rst_req", {31'b0, dmem_req_o}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
    tick();
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h12345678;
    tick();
    dmem_rvalid_i = 0; dmem_rdata_i = 0;
    @(negedge clk_i);
    chk("late_rvalid_valid", {31'b0, wb_valid_o}, 32'h0);
    chk("late_rvalid_busy", {31'b0, busy_o}, 32'h0);
    idle(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage between execute and writeback.
- Takes one execute-stage result per cycle and drives the data-memory request/grant/response bus for loads and stores.
- Aligns and sign-extends load data, then presents a registered writeback bundle: alu_out, mem_dout, next_pc, rf_wr_en, rf_wr_src, mem_read, rd.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- RESP_BUF_EN, 1, when 1 a one-entry hold buffer absorbs a response that arrives while stall_i is high; when 0, stall_i is only legal while in IDLE.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  execute-stage instruction valid
- alu_out_i  in  32  ALU result / effective address
- store_data_i  in  32  rs2 value for stores
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- mem_width_i  in  2  0=byte 1=half 2=word (3 treated as word)
- mem_sign_i  in  1  1=sign-extend load
- rf_wr_en_i  in  1  writes rd
- rf_wr_src_i  in  2  ALU/MEM/CSR/PC_PLUS_4 encoding, passed through
- next_pc_i  in  32  PC+4
- rd_i  in  5  destination register
- stall_i  in  1  hold outputs (from stage control)
- squash_i  in  1  kill the instruction in this stage
- busy_o  out  1  upstream must hold; combinational
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  write
- dmem_addr_o  out  32  word-aligned address {alu_out[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response (loads and stores)
- dmem_rdata_i  in  32  read data
- wb_valid_o, wb_alu_out_o[31:0], wb_mem_dout_o[31:0], wb_next_pc_o[31:0], wb_rf_wr_en_o, wb_rf_wr_src_o[1:0], wb_mem_read_o, wb_rd_o[4:0]  out  registered writeback bundle
- misalign_o  out  1  one-cycle pulse on a suppressed misaligned access

Behaviour:
- Reset: state IDLE; every output 0; dmem_req_o=0; drop flag cleared. Reset mid-transaction abandons it; any late rvalid seen in IDLE is ignored.
- States: IDLE, REQ (req held, awaiting gnt), RESP (awaiting rvalid), HOLD (response buffered, stall_i high).
- Non-memory instruction, IDLE, !stall_i: WB bundle registered next edge (latency 1); wb_valid_o = valid_i & !squash_i. stall_i high: WB bundle holds.
- Memory access (valid_i & (mem_read_i|mem_write_i) & !squash_i & !stall_i) in IDLE:
  - dmem_req_o asserted combinationally; request fields captured.
  - gnt same cycle -> RESP, else -> REQ.
  - wb_valid_o goes 0 next edge.
- REQ: req and all request fields stable until gnt, then -> RESP.
- RESP: on rvalid, if !stall_i load WB bundle with wb_valid_o = !drop, then -> IDLE. If stall_i is high -> HOLD (data buffered).
- HOLD: on stall_i low, load WB bundle from buffer -> IDLE.
- busy_o = (state!=IDLE) | (IDLE & new memory access). Low in the cycle the WB bundle loads.
- Squash:
  - IDLE: no request issued.
  - REQ/RESP/HOLD: set drop. The request is still not withdrawn (req held to gnt) and the response is still consumed. The result is written with wb_valid_o=0 and wb_rf_wr_en_o=0.
- Load data, off=addr[1:0]:
  - byte: rdata[8*off+:8]
  - half: rdata[16*addr[1]+:16]
  - word: rdata
  - zero- or sign-extended per mem_sign.
- Store byte enables and data:
  - byte: be=4'b0001<<off, wdata={4{data[7:0]}}
  - half: be=4'b0011<<(2*addr[1]), wdata={2{data[15:0]}}
  - word: be=4'hF, wdata=data.
- dmem_be_o=4'hF for loads.
- Stores return rvalid; wb_mem_dout_o=0 for stores.
- gnt and rvalid in the same cycle while in REQ are treated as a complete transaction.

Optional Feature:
- MEM_STAGE_MISALIGN_CHECK_EN defined:
  - half with addr[0]=1, or word with addr[1:0]!=0: no bus request.
  - WB bundle loads next edge with wb_rf_wr_en_o=0.
  - misalign_o pulses one cycle.
- Undefined:
  - misalign_o tied 0.
  - Low address bits beyond lane selection are ignored; the access proceeds on the aligned word using the enable rules above.

Test Plan:
- lw addr 0x100, gnt after 2 cycles, rvalid 3 cycles later, rdata 0xDEADBEEF -> busy_o high 5 cycles; wb_mem_dout_o=0xDEADBEEF, wb_valid_o=1.
- lb signed addr 0x103, rdata 0x80000000 -> 0xFFFFFF80; lbu same -> 0x00000080.
- sh addr 0x102, data 0x1234ABCD -> be=4'b1100, wdata=0xABCDABCD, we=1; wb_rf_wr_en_o=0.
- lw issued, squash_i pulsed in RESP, rvalid -> wb_valid_o=0, FSM returns to IDLE, next add completes in 1 cycle.
- stall_i high when rvalid arrives (RESP->HOLD), released 2 cycles later -> WB bundle loads with the buffered data, no second request.
- MEM_STAGE_MISALIGN_CHECK_EN, lw addr 0x1001 -> dmem_req_o never high, misalign_o=1 for one cycle, wb_rf_wr_en_o=0.
